// File: rtl/sad_pkg.sv
// Shared widths, constants and FSM state encoding for the SAD minimum search block.
package sad_pkg;
    localparam int SAD_W = 12;
    localparam logic [SAD_W-1:0] SAD_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/sad_pos_counter.sv
// Raster-order (x,y) position counter: x runs fastest and wraps into y.
module sad_pos_counter #(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [$clog2(W)-1:0] x,
    output logic [$clog2(H)-1:0] y,
    output logic                 last
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic x_end;
    logic y_end;

    assign x_end = (x == XW'(W - 1));
    assign y_end = (y == YW'(H - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sad_min_search.sv
// Tracks the first raster-order minimum SAD over a SEARCH_W x SEARCH_H window.
// Optional SAD_EARLY_TERM_EN: a zero SAD ends the search immediately.
//
// state     | meaning
// ST_IDLE   | waiting for start; last result stays on the outputs
// ST_SEARCH | consuming candidates, busy=1
// ST_DONE   | result offered with best_valid until best_ready
module sad_min_search
    import sad_pkg::*;
#(
    parameter int SEARCH_W = 16,
    parameter int SEARCH_H = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        sad_valid,
    input  logic [SAD_W-1:0]            sad,
    output logic                        busy,
    output logic                        best_valid,
    input  logic                        best_ready,
    output logic [SAD_W-1:0]            best_sad,
    output logic [$clog2(SEARCH_W)-1:0] best_x,
    output logic [$clog2(SEARCH_H)-1:0] best_y
);
    localparam int XW = $clog2(SEARCH_W);
    localparam int YW = $clog2(SEARCH_H);

    state_t         state;
    state_t         state_nxt;
    logic           clear;
    logic           take;
    logic           early_hit;
    logic           last_pos;
    logic [XW-1:0]  pos_x;
    logic [YW-1:0]  pos_y;

`ifdef SAD_EARLY_TERM_EN
    assign early_hit = (sad == '0);
`else
    assign early_hit = 1'b0;
`endif

    sad_pos_counter #(
        .W (SEARCH_W),
        .H (SEARCH_H)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (take),
        .x       (pos_x),
        .y       (pos_y),
        .last    (last_pos)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // start in SEARCH wins over a coincident sad_valid; start in DONE is ignored
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (start) begin
                    clear = 1'b1;
                end else if (sad_valid) begin
                    take = 1'b1;
                    if (last_pos || early_hit) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (best_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strict less-than keeps the earliest minimum and never lets SAD_MAX replace the seed
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            best_sad <= SAD_MAX;
            best_x   <= '0;
            best_y   <= '0;
        end else if (take && (sad < best_sad)) begin
            best_sad <= sad;
            best_x   <= pos_x;
            best_y   <= pos_y;
        end
    end

    assign busy       = (state == ST_SEARCH);
    assign best_valid = (state == ST_DONE);
endmodule

// File: doc/sad_min_search.md
SAD_MIN_SEARCH -- requirements
Module: sad_min_search

Interface
REQ-001 SHALL have parameter SEARCH_W, default 16, meaning candidate positions per search row (2..256).
REQ-002 SHALL have parameter SEARCH_H, default 16, meaning candidate rows per search (2..256).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a new search and clear the running best.
REQ-006 SHALL have port sad_valid  input  1  sad carries a candidate SAD this cycle.
REQ-007 SHALL have port sad  input  12  candidate SAD from the PE array, raster order.
REQ-008 SHALL have port busy  output  1  high while in SEARCH.
REQ-009 SHALL have port best_valid  output  1  result available.
REQ-010 SHALL have port best_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port best_sad  output  12  minimum SAD found.
REQ-012 SHALL have port best_x  output  $clog2(SEARCH_W)  column of the minimum.
REQ-013 SHALL have port best_y  output  $clog2(SEARCH_H)  row of the minimum.

Function
REQ-014 SHALL implement FSM states IDLE, SEARCH and DONE.
REQ-015 IDLE: start=1 -> SEARCH next cycle; pos_x=pos_y=0; best_sad=12'hFFF; best_x=best_y=0.
REQ-016 SEARCH: each sad_valid=1 cycle is one candidate at (pos_x,pos_y); sad_valid=0 cycles are stalls with no state change.
REQ-017 A candidate SHALL replace the best only if sad < best_sad (strict), so the first raster-order minimum wins ties.
REQ-018 On an accepted candidate, pos_x SHALL increment; at SEARCH_W-1 it wraps to 0 and pos_y increments.
REQ-019 The candidate at (SEARCH_W-1, SEARCH_H-1) SHALL be compared, then FSM -> DONE with best_valid=1 on the next cycle (latency 1).
REQ-020 DONE: best_valid, best_sad, best_x and best_y SHALL be held stable until best_valid and best_ready are both high; then -> IDLE.
REQ-021 sad_valid in IDLE or DONE SHALL be ignored.
REQ-022 start in SEARCH SHALL abort and restart: counters and best re-initialised as in REQ-015, FSM stays in SEARCH; a coincident sad_valid is discarded.
REQ-023 start in DONE SHALL be ignored; the result is never dropped without a handshake.
REQ-024 best_ready=1 with start=1 in the same DONE cycle SHALL complete the handshake and return to IDLE; start is not captured.
REQ-025 sad=12'hFFF SHALL never replace the initial best, so an all-saturated search reports (0,0) with 12'hFFF.
REQ-026 busy SHALL equal (state==SEARCH); best_valid SHALL equal (state==DONE).

Reset
REQ-027 On rst_n=0 at a clock edge: state=IDLE, busy=0, best_valid=0, best_sad=12'hFFF, best_x=0, best_y=0, counters=0.
REQ-028 Reset mid-SEARCH or mid-DONE SHALL discard the partial or pending result, with no output handshake.

Configuration
REQ-029 Macro SAD_EARLY_TERM_EN: when defined, an accepted candidate with sad==0 SHALL record it and enter DONE next cycle, ignoring remaining candidates.
REQ-030 Without SAD_EARLY_TERM_EN, every search SHALL consume exactly SEARCH_W*SEARCH_H candidates.

Structure
REQ-031 Shared package sad_pkg SHALL hold SAD_W=12, SAD_MAX=12'hFFF and the FSM state enum.
REQ-032 One sub-module, sad_pos_counter, SHALL implement the raster (x,y) counter with clear, advance and a last-position flag.

Verification
REQ-033 Ramp: W=H=4, sad=100-idx for idx 0..15 -> best_sad=85, (3,3), best_valid one cycle after the last sad_valid.
REQ-034 Tie: W=H=4, sad=50 everywhere except 20 at idx 5 and idx 9 -> (1,1), best_sad=20.
REQ-035 Backpressure: best_ready=0 for 10 cycles in DONE, start pulsed and sad_valid toggled -> outputs held and no restart; best_ready=1 -> IDLE next cycle.
REQ-036 Abort: start at candidate 7 (min 3 at idx 2), new stream with min 40 at idx 12 -> (0,3), best_sad=40.
REQ-037 Stalls and reset: sad_valid at 50% random duty gives the same result as REQ-033; rst_n=0 mid-SEARCH -> IDLE, best_sad=12'hFFF, best_valid=0.
REQ-038 Early term: with SAD_EARLY_TERM_EN, sad=0 at idx 3 -> DONE next cycle, (3,0), best_sad=0; without the macro -> all 16 candidates consumed, same result.
